// File: rtl/pong_collision_if.sv
// Bus between the pong top level and the collision detector: sampled positions,
// serve handshake, and the collision/score pulses.
interface pong_collision_if #(
  parameter int x_coords_width = 10,
  parameter int y_coords_width = 10
);
  logic                      frame_tick;
  logic [x_coords_width-1:0] ball_x;
  logic [y_coords_width-1:0] ball_y;
  logic [y_coords_width-1:0] lpaddle_y;
  logic [y_coords_width-1:0] rpaddle_y;
  logic                      serve_ack;
  logic                      touching_paddle;
  logic                      touching_wall;
  logic                      score_left;
  logic                      score_right;
  logic                      serve_req;
  logic                      busy;

  modport master (
    output frame_tick, ball_x, ball_y, lpaddle_y, rpaddle_y, serve_ack,
    input  touching_paddle, touching_wall, score_left, score_right, serve_req, busy
  );

  modport slave (
    input  frame_tick, ball_x, ball_y, lpaddle_y, rpaddle_y, serve_ack,
    output touching_paddle, touching_wall, score_left, score_right, serve_req, busy
  );
endinterface

// File: rtl/pong_collision.sv
// Frame-rate collision and scoring detector: captures positions on frame_tick,
// evaluates paddle/wall/miss conditions and emits cooldown-limited pulses.
module pong_collision #(
  parameter int x_coords_width  = 10,
  parameter int y_coords_width  = 10,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int TOP_Y           = 4,
  parameter int BALL_SIZE       = 8,
  parameter int PADDLE_W        = 8,
  parameter int PADDLE_H        = 64,
  parameter int LEFT_PADDLE_X   = 16,
  parameter int RIGHT_PADDLE_X  = 616,
  parameter int WRAP_BAND       = 32,
  parameter int COOLDOWN_FRAMES = 4
) (
  input logic             clk,
  input logic             reset,
  pong_collision_if.slave bus
);
  localparam int XE      = x_coords_width + 1;
  localparam int YE      = y_coords_width + 1;
  localparam int CW      = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam int WRAP_LO = (1 << x_coords_width) - WRAP_BAND;
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_FRAMES);
  localparam logic [CW-1:0] CD_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    EMIT  = 2'd2,
    SERVE = 2'd3
  } state_t;

  state_t                    state_r, next_state_s;
  logic [x_coords_width-1:0] cap_x_r;
  logic [y_coords_width-1:0] cap_y_r, cap_lp_r, cap_rp_r;
  logic [XE-1:0]             x_e_s;
  logic [YE-1:0]             y_e_s, lp_e_s, rp_e_s;
  logic                      lovl_s, rovl_s, wall_s, wrap_s, lmiss_s, rmiss_s;
  logic                      pad_flag_r, wall_flag_r, lmiss_r, rmiss_r;
  logic [CW-1:0]             pad_cd_r, wall_cd_r, pad_cd_s, wall_cd_s;
  logic                      tp_r, tw_r, sl_r, sr_r, sreq_r, busy_r;
  logic                      tp_s, tw_s, sl_s, sr_s, sreq_s, busy_s;
  logic                      unused_s;

  // The playfield width does not enter any collision rule.
  assign unused_s = (SCREEN_W != 32'sd0);

  function automatic logic [CW-1:0] cd_step(input logic [CW-1:0] cd);
    if (cd != CD_ZERO) begin
      return cd - CW'(1'b1);
    end else begin
      return CD_ZERO;
    end
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state logic; ticks outside IDLE are dropped.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (bus.frame_tick) next_state_s = CHECK; else next_state_s = IDLE;
      CHECK:   next_state_s = EMIT;
      EMIT:    if (lmiss_r || rmiss_r) next_state_s = SERVE; else next_state_s = IDLE;
      SERVE:   if (bus.serve_ack) next_state_s = IDLE; else next_state_s = SERVE;
      default: next_state_s = IDLE;
    endcase
  end

  // Position capture on an accepted tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_x_r  <= '0;
      cap_y_r  <= '0;
      cap_lp_r <= '0;
      cap_rp_r <= '0;
    end else if (state_r == IDLE && bus.frame_tick) begin
      cap_x_r  <= bus.ball_x;
      cap_y_r  <= bus.ball_y;
      cap_lp_r <= bus.lpaddle_y;
      cap_rp_r <= bus.rpaddle_y;
    end
  end

  // Geometry tests, widened by one bit so sums never wrap.
  always_comb begin
    x_e_s   = {1'b0, cap_x_r};
    y_e_s   = {1'b0, cap_y_r};
    lp_e_s  = {1'b0, cap_lp_r};
    rp_e_s  = {1'b0, cap_rp_r};
    lovl_s  = (x_e_s <= XE'(LEFT_PADDLE_X + PADDLE_W)) &&
              (x_e_s + XE'(BALL_SIZE) >= XE'(LEFT_PADDLE_X)) &&
              (y_e_s + YE'(BALL_SIZE) > lp_e_s) && (y_e_s < lp_e_s + YE'(PADDLE_H));
    rovl_s  = (x_e_s <= XE'(RIGHT_PADDLE_X + PADDLE_W)) &&
              (x_e_s + XE'(BALL_SIZE) >= XE'(RIGHT_PADDLE_X)) &&
              (y_e_s + YE'(BALL_SIZE) > rp_e_s) && (y_e_s < rp_e_s + YE'(PADDLE_H));
    wall_s  = (y_e_s <= YE'(TOP_Y)) || (y_e_s + YE'(BALL_SIZE) >= YE'(SCREEN_H)) ||
              (y_e_s >= YE'(SCREEN_H));
    wrap_s  = (x_e_s >= XE'(WRAP_LO));
    lmiss_s = !(lovl_s || rovl_s) && ((x_e_s < XE'(LEFT_PADDLE_X)) || wrap_s);
    rmiss_s = !(lovl_s || rovl_s) && (x_e_s > XE'(RIGHT_PADDLE_X + PADDLE_W)) && !wrap_s;
  end

  // Flag register, loaded in CHECK.
  always_ff @(posedge clk) begin
    if (reset) begin
      pad_flag_r  <= 1'b0;
      wall_flag_r <= 1'b0;
      lmiss_r     <= 1'b0;
      rmiss_r     <= 1'b0;
    end else if (state_r == CHECK) begin
      pad_flag_r  <= lovl_s || rovl_s;
      wall_flag_r <= wall_s;
      lmiss_r     <= lmiss_s;
      rmiss_r     <= rmiss_s;
    end
  end

  // Output and cooldown next values; a miss masks paddle and wall pulses.
  always_comb begin
    tp_s      = 1'b0;
    tw_s      = 1'b0;
    sl_s      = 1'b0;
    sr_s      = 1'b0;
    pad_cd_s  = pad_cd_r;
    wall_cd_s = wall_cd_r;
    case (state_r)
      EMIT: begin
        if (lmiss_r || rmiss_r) begin
          sr_s      = lmiss_r;
          sl_s      = rmiss_r;
          pad_cd_s  = cd_step(pad_cd_r);
          wall_cd_s = cd_step(wall_cd_r);
        end else begin
          if (pad_flag_r && pad_cd_r == CD_ZERO) begin
            tp_s     = 1'b1;
            pad_cd_s = CD_LOAD;
          end else begin
            pad_cd_s = cd_step(pad_cd_r);
          end
          if (wall_flag_r && wall_cd_r == CD_ZERO) begin
            tw_s      = 1'b1;
            wall_cd_s = CD_LOAD;
          end else begin
            wall_cd_s = cd_step(wall_cd_r);
          end
        end
      end
      SERVE: begin
        if (bus.serve_ack) begin
          pad_cd_s  = CD_ZERO;
          wall_cd_s = CD_ZERO;
        end else begin
          pad_cd_s  = pad_cd_r;
          wall_cd_s = wall_cd_r;
        end
      end
      default: begin
        pad_cd_s  = pad_cd_r;
        wall_cd_s = wall_cd_r;
      end
    endcase
    sreq_s = (next_state_s == SERVE);
    busy_s = (next_state_s != IDLE);
  end

  // Registered outputs and cooldown counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      tp_r      <= 1'b0;
      tw_r      <= 1'b0;
      sl_r      <= 1'b0;
      sr_r      <= 1'b0;
      sreq_r    <= 1'b0;
      busy_r    <= 1'b0;
      pad_cd_r  <= CD_ZERO;
      wall_cd_r <= CD_ZERO;
    end else begin
      tp_r      <= tp_s;
      tw_r      <= tw_s;
      sl_r      <= sl_s;
      sr_r      <= sr_s;
      sreq_r    <= sreq_s;
      busy_r    <= busy_s;
      pad_cd_r  <= pad_cd_s;
      wall_cd_r <= wall_cd_s;
    end
  end

  assign bus.touching_paddle = tp_r;
  assign bus.touching_wall   = tw_r;
  assign bus.score_left      = sl_r;
  assign bus.score_right     = sr_r;
  assign bus.serve_req       = sreq_r;
  assign bus.busy            = busy_r;
endmodule

// File: tb/tb_pong_collision.sv
// Self-checking bench for pong_collision: directed scenarios plus randomized
// ticks against a rule-level reference model. Output vector {paddle,wall,sl,sr,serve_req,busy}.
module tb_pong_collision;
  localparam int LPX = 16, RPX = 616, PW = 8, PH = 64, BS = 8;
  localparam int TOP = 4, SH = 480, WRAP_LO = 1024 - 32, CD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int m_pcd = 0, m_wcd = 0;
  bit m_serve = 1'b0;
  logic [5:0] s0, s1, s2, s3;

  pong_collision_if #(.x_coords_width(10), .y_coords_width(10)) bus ();
  pong_collision dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {bus.touching_paddle, bus.touching_wall, bus.score_left,
            bus.score_right, bus.serve_req, bus.busy};
  endfunction

  // Reference: one evaluation from the game rules; returns EMIT-cycle and busy-phase outputs.
  task automatic model_tick(input int x, y, lp, rp, output logic [5:0] e_emit, output logic [5:0] e_busy);
    bit lo, ro, wall, wrap, lmiss, rmiss, tp, tw;
    if (m_serve) begin
      e_emit = 6'b000011;
      e_busy = 6'b000011;
      return;
    end
    e_busy = 6'b000001;
    lo    = (x <= LPX + PW) && (x + BS >= LPX) && (y + BS > lp) && (y < lp + PH);
    ro    = (x <= RPX + PW) && (x + BS >= RPX) && (y + BS > rp) && (y < rp + PH);
    wall  = (y <= TOP) || (y + BS >= SH) || (y >= SH);
    wrap  = (x >= WRAP_LO);
    lmiss = !(lo || ro) && (x < LPX || wrap);
    rmiss = !(lo || ro) && (x > RPX + PW) && !wrap;
    if (lmiss || rmiss) begin
      e_emit  = {2'b00, rmiss, lmiss, 2'b11};
      m_serve = 1'b1;
      if (m_pcd > 0) m_pcd--;
      if (m_wcd > 0) m_wcd--;
    end else begin
      tp = (lo || ro) && (m_pcd == 0);
      tw = wall && (m_wcd == 0);
      m_pcd = tp ? CD : (m_pcd > 0 ? m_pcd - 1 : 0);
      m_wcd = tw ? CD : (m_wcd > 0 ? m_wcd - 1 : 0);
      e_emit = {tp, tw, 4'b0000};
    end
  endtask

  // Drives one tick (4-cycle spacing) and samples outputs after edges N..N+3.
  task automatic apply_tick(input int x, y, lp, rp);
    @(negedge clk);
    bus.ball_x = 10'(x); bus.ball_y = 10'(y);
    bus.lpaddle_y = 10'(lp); bus.rpaddle_y = 10'(rp);
    bus.frame_tick = 1'b1;
    @(negedge clk); bus.frame_tick = 1'b0; s0 = outs();
    @(negedge clk); s1 = outs();
    @(negedge clk); s2 = outs();
    @(negedge clk); s3 = outs();
  endtask

  task automatic do_serve_ack();
    @(negedge clk); bus.serve_ack = 1'b1;
    @(negedge clk); bus.serve_ack = 1'b0;
    if (m_serve) begin
      m_serve = 1'b0; m_pcd = 0; m_wcd = 0;
    end
  endtask

  task automatic test_reset();
    logic [5:0] o;
    bus.ball_x = 10'd20; bus.ball_y = 10'd200; bus.lpaddle_y = 10'd180;
    bus.frame_tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); o = outs();
      vectors++;
      if (o !== 6'b000000) begin
        miscompares++; $display("FAIL reset[%0d]: got %b expected %b", i, o, 6'b000000);
      end
    end
    bus.frame_tick = 1'b0;
    reset = 1'b0;
    @(negedge clk); o = outs();
    vectors++;
    if (o !== 6'b000000) begin
      miscompares++; $display("FAIL reset_release: got %b expected %b", o, 6'b000000);
    end
  endtask

  task automatic test_paddle_cooldown();
    logic [5:0] e2, e0;
    logic [5:0] exp_t [6] = '{6'b100000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b100000};
    for (int i = 0; i < 6; i++) begin
      model_tick(20, 200, 180, 200, e2, e0);
      apply_tick(20, 200, 180, 200);
      vectors++;
      if (s0 !== 6'b000001) begin
        miscompares++; $display("FAIL paddle_busy[%0d]: got %b expected %b", i, s0, 6'b000001);
      end
      vectors++;
      if (s2 !== exp_t[i]) begin
        miscompares++; $display("FAIL paddle_cooldown[%0d]: got %b expected %b", i, s2, exp_t[i]);
      end
      vectors++;
      if (s3 !== 6'b000000) begin
        miscompares++; $display("FAIL paddle_one_cycle[%0d]: got %b expected %b", i, s3, 6'b000000);
      end
    end
  endtask

  task automatic test_walls();
    logic [5:0] e2, e0, ex;
    int ys [3] = '{0, 476, 1018};
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 5; k++) begin
        int y;
        y  = (k == 0) ? ys[w] : 200;
        ex = (k == 0) ? 6'b010000 : 6'b000000;
        model_tick(300, y, 300, 200, e2, e0);
        apply_tick(300, y, 300, 200);
        vectors++;
        if (s2 !== ex) begin
          miscompares++; $display("FAIL wall[y=%0d,k=%0d]: got %b expected %b", y, k, s2, ex);
        end
      end
    end
  endtask

  task automatic test_corner();
    logic [5:0] e2, e0;
    logic [5:0] exp_t [2] = '{6'b110000, 6'b000000};
    for (int i = 0; i < 2; i++) begin
      model_tick(20, 2, 0, 200, e2, e0);
      apply_tick(20, 2, 0, 200);
      vectors++;
      if (s2 !== exp_t[i]) begin
        miscompares++; $display("FAIL corner[%0d]: got %b expected %b", i, s2, exp_t[i]);
      end
    end
  endtask

  task automatic test_miss_serve();
    logic [5:0] e2, e0, o;
    int xs [3] = '{5, 1000, 700};
    logic [5:0] exp_t [3] = '{6'b000111, 6'b000111, 6'b001011};
    for (int i = 0; i < 3; i++) begin
      model_tick(xs[i], 100, 300, 200, e2, e0);
      apply_tick(xs[i], 100, 300, 200);
      vectors++;
      if (s2 !== exp_t[i]) begin
        miscompares++; $display("FAIL miss[x=%0d]: got %b expected %b", xs[i], s2, exp_t[i]);
      end
      vectors++;
      if (s3 !== 6'b000011) begin
        miscompares++; $display("FAIL serve_hold[x=%0d]: got %b expected %b", xs[i], s3, 6'b000011);
      end
      if (i == 0) begin
        model_tick(20, 200, 180, 200, e2, e0);
        apply_tick(20, 200, 180, 200);
        vectors++;
        if (s2 !== 6'b000011 || s3 !== 6'b000011) begin
          miscompares++; $display("FAIL serve_tick_ignored: got %b/%b expected %b", s2, s3, 6'b000011);
        end
      end
      do_serve_ack();
      o = outs();
      vectors++;
      if (o !== 6'b000000) begin
        miscompares++; $display("FAIL serve_ack[x=%0d]: got %b expected %b", xs[i], o, 6'b000000);
      end
    end
    // Ack outside SERVE must not clear the paddle cooldown.
    model_tick(20, 200, 180, 200, e2, e0);
    apply_tick(20, 200, 180, 200);
    vectors++;
    if (s2 !== 6'b100000) begin
      miscompares++; $display("FAIL post_serve_hit: got %b expected %b", s2, 6'b100000);
    end
    do_serve_ack();
    model_tick(20, 200, 180, 200, e2, e0);
    apply_tick(20, 200, 180, 200);
    vectors++;
    if (s2 !== 6'b000000) begin
      miscompares++; $display("FAIL idle_ack_ignored: got %b expected %b", s2, 6'b000000);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] e2, e0, o;
    @(negedge clk);
    bus.ball_x = 10'd20; bus.ball_y = 10'd2; bus.lpaddle_y = 10'd0; bus.rpaddle_y = 10'd200;
    bus.frame_tick = 1'b1;
    @(negedge clk); bus.frame_tick = 1'b0; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); o = outs();
      vectors++;
      if (o !== 6'b000000) begin
        miscompares++; $display("FAIL reset_mid[%0d]: got %b expected %b", i, o, 6'b000000);
      end
    end
    reset = 1'b0;
    m_serve = 1'b0; m_pcd = 0; m_wcd = 0;
    model_tick(20, 200, 180, 200, e2, e0);
    apply_tick(20, 200, 180, 200);
    vectors++;
    if (s2 !== 6'b100000) begin
      miscompares++; $display("FAIL reset_clears_cooldown: got %b expected %b", s2, 6'b100000);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] e2, e0;
    model_tick(300, 0, 300, 200, e2, e0);
    @(negedge clk);
    bus.ball_x = 10'd300; bus.ball_y = 10'd0; bus.lpaddle_y = 10'd300; bus.rpaddle_y = 10'd200;
    bus.frame_tick = 1'b1;
    @(negedge clk); s0 = outs(); bus.ball_x = 10'd5; bus.ball_y = 10'd100;
    @(negedge clk); s1 = outs();
    @(negedge clk); s2 = outs(); bus.frame_tick = 1'b0;
    @(negedge clk); s3 = outs();
    vectors++;
    if (s1 !== 6'b000001) begin
      miscompares++; $display("FAIL b2b_busy: got %b expected %b", s1, 6'b000001);
    end
    vectors++;
    if (s2 !== 6'b010000) begin
      miscompares++; $display("FAIL b2b_first_eval: got %b expected %b", s2, 6'b010000);
    end
    vectors++;
    if (s3 !== 6'b000000) begin
      miscompares++; $display("FAIL b2b_dropped: got %b expected %b", s3, 6'b000000);
    end
  endtask

  task automatic test_random();
    logic [5:0] e2, e0, o;
    int x, y, lp, rp;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0:       x = $urandom_range(0, 40);
        1:       x = $urandom_range(600, 660);
        2:       x = $urandom_range(0, 1023);
        default: x = $urandom_range(960, 1023);
      endcase
      y  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 490);
      lp = $urandom_range(0, 470);
      rp = $urandom_range(0, 470);
      model_tick(x, y, lp, rp, e2, e0);
      apply_tick(x, y, lp, rp);
      vectors++;
      if (s0 !== e0 || s1 !== e0) begin
        miscompares++; $display("FAIL rand_busy[%0d]: got %b/%b expected %b", i, s0, s1, e0);
      end
      vectors++;
      if (s2 !== e2) begin
        miscompares++; $display("FAIL rand_emit[%0d] (%0d,%0d,%0d,%0d): got %b expected %b",
                                i, x, y, lp, rp, s2, e2);
      end
      vectors++;
      if (s3 !== (e2 & 6'b000011)) begin
        miscompares++; $display("FAIL rand_after[%0d]: got %b expected %b", i, s3, e2 & 6'b000011);
      end
      if (m_serve && $urandom_range(0, 1) == 1) begin
        do_serve_ack();
        o = outs();
        vectors++;
        if (o !== 6'b000000) begin
          miscompares++; $display("FAIL rand_ack[%0d]: got %b expected %b", i, o, 6'b000000);
        end
      end
    end
  endtask

  initial begin
    bus.frame_tick = 1'b0; bus.serve_ack = 1'b0;
    bus.ball_x = 10'd0; bus.ball_y = 10'd0; bus.lpaddle_y = 10'd0; bus.rpaddle_y = 10'd0;
    test_reset();
    test_paddle_cooldown();
    test_walls();
    test_corner();
    test_miss_serve();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/pong_collision.md
# pong_collision

Frame-rate collision and scoring detector for the pong datapath. Once per `frame_tick` it samples the ball and paddle positions and produces the one-cycle `touching_paddle` / `touching_wall` pulses that drive the ball position updater's direction flips. It also detects missed balls, issues score pulses and holds the game in a serve handshake until the top level re-serves.

## Interface

Parameters (name, default, meaning):

- `x_coords_width`, 10: ball/paddle X width.
- `y_coords_width`, 10: ball/paddle Y width.
- `SCREEN_W`, 640: playfield width in pixels.
- `SCREEN_H`, 480: playfield height in pixels.
- `TOP_Y`, 4: top wall line; `ball_y <= TOP_Y` is a wall hit.
- `BALL_SIZE`, 8: ball square edge.
- `PADDLE_W`, 8: paddle width.
- `PADDLE_H`, 64: paddle height.
- `LEFT_PADDLE_X`, 16: left paddle left edge.
- `RIGHT_PADDLE_X`, 616: right paddle left edge.
- `WRAP_BAND`, 32: top `WRAP_BAND` X codes are treated as left underflow.
- `COOLDOWN_FRAMES`, 4: evaluations during which a repeat pulse of the same type is suppressed.

Ports (name, direction, width, meaning):

- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`, in, 1: clock.
  - `reset`, in, 1: synchronous, active-high.
- `frame_tick`, in, 1: one-cycle evaluation request.
- `ball_x`, in, `x_coords_width`: ball top-left X.
- `ball_y`, in, `y_coords_width`: ball top-left Y.
- `lpaddle_y`, in, `y_coords_width`: left paddle top Y.
- `rpaddle_y`, in, `y_coords_width`: right paddle top Y.
- `serve_ack`, in, 1: top level has re-served the ball.
- `touching_paddle`, out, 1: one-cycle pulse on a paddle hit.
- `touching_wall`, out, 1: one-cycle pulse on a top/bottom wall hit.
- `score_left`, out, 1: one-cycle pulse; left player scores (right miss).
- `score_right`, out, 1: one-cycle pulse; right player scores (left miss).
- `serve_req`, out, 1: level, high while waiting for `serve_ack`.
- `busy`, out, 1: high in any state other than IDLE.

## Operation

- FSM states: IDLE, CHECK, EMIT, SERVE.
- IDLE:
  - `frame_tick` high latches all four position inputs into capture registers and moves to CHECK.
- CHECK:
  - Registers the comparison flags below from the captured values.
  - Goes to EMIT.
- Comparison flags (all arithmetic one bit wider than the operand, no wrap):
  - Left paddle overlap: `x <= LEFT_PADDLE_X+PADDLE_W` and `x+BALL_SIZE >= LEFT_PADDLE_X` and `y+BALL_SIZE > lpaddle_y` and `y < lpaddle_y+PADDLE_H`.
  - Right paddle overlap: same test using `RIGHT_PADDLE_X` and `rpaddle_y`.
  - Wall: `y <= TOP_Y` or `y+BALL_SIZE >= SCREEN_H` or `y >= SCREEN_H` (underflow).
  - Left miss: no paddle overlap and (`x < LEFT_PADDLE_X` or `x >= 2^x_coords_width - WRAP_BAND`).
  - Right miss: no paddle overlap and `x > RIGHT_PADDLE_X+PADDLE_W` and not in the wrap band.
- EMIT:
  - A miss pulses `score_right` (left miss) or `score_left` (right miss) and goes to SERVE.
  - A miss suppresses the paddle and wall pulses for that evaluation.
  - Otherwise, paddle overlap pulses `touching_paddle` if its cooldown counter is 0, and wall pulses `touching_wall` if its cooldown counter is 0.
  - Paddle and wall pulses may fire in the same cycle.
  - Then returns to IDLE.
- Cooldown: two independent counters, one for paddle and one for wall.
  - An emitted pulse loads its counter with `COOLDOWN_FRAMES`.
  - A non-zero counter blocks that pulse type.
  - Each EMIT with a non-zero counter decrements it by 1.
- SERVE:
  - `serve_req` is high.
  - `frame_tick` is ignored.
  - `serve_ack` returns the FSM to IDLE and clears both cooldown counters.
- `frame_tick` arriving in CHECK or EMIT is dropped, not queued.

## Timing

- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Cooldown counters and capture registers 0.
- Reset has priority over every other event, including mid-CHECK, mid-EMIT and mid-SERVE; no pulse is emitted after reset is sampled.
- Latency:
  - `frame_tick` sampled at edge N.
  - Flags registered at edge N+1.
  - Pulse outputs high for exactly the one cycle following edge N+2.
- `busy` is high from edge N through edge N+2, and stays high throughout SERVE.
- `serve_req` rises at edge N+2 with the score pulse and falls at the edge that samples `serve_ack` high.
- `serve_ack` outside SERVE is ignored.
- Minimum tick spacing for every tick to be evaluated: 3 cycles.

## Test plan

- Left paddle hit: ball (20,200), `lpaddle_y`=180, tick -> `touching_paddle` one cycle at N+2; `touching_wall`=0, scores=0.
- Cooldown: repeat the left paddle hit for ticks 2-6 with 4-cycle spacing -> ticks 2-5 emit nothing; tick 6 pulses `touching_paddle`.
- Walls: ball (300,0) -> `touching_wall`; ball (300,476) -> `touching_wall`; ball (300,1018) (underflow) -> `touching_wall`.
- Corner: ball (20,2), `lpaddle_y`=0 -> `touching_paddle` and `touching_wall` in the same cycle.
- Miss and serve: ball (5,100), `lpaddle_y`=300 -> `score_right` pulse and `serve_req`=1. Then a tick -> no outputs. Then `serve_ack` -> `serve_req` 0 next cycle, `busy` 0. Then ball (1000,100) -> `score_right`; ball (700,100) -> `score_left`.
- Reset mid-operation: tick, then assert `reset` at N+1 -> no pulse at N+2, all outputs 0, FSM IDLE.
